// File: rtl/smi_fifo_bridge.sv
// Bridge between the Raspberry Pi SMI bus (asynchronous strobes) and two fabric-side
// FIFO streams: RX carries Pi writes into the fabric, TX carries fabric words out to Pi reads.
module smi_fifo_bridge #(
    parameter int               WIDTH       = 8,
    parameter int               RX_DEPTH    = 16,
    parameter int               TX_DEPTH    = 16,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] IDLE_WORD   = '0
) (
    input  logic                        CLK,
    input  logic                        reset_n,
    input  logic                        smi_oe_n,
    input  logic                        smi_we_n,
    input  logic [WIDTH-1:0]            smi_d_in,
    output logic [WIDTH-1:0]            smi_d_out,
    output logic                        smi_d_oe,
    output logic [WIDTH-1:0]            rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    input  logic [WIDTH-1:0]            tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic                        rx_overflow,
    output logic                        tx_underrun,
    input  logic                        flags_clr,
    output logic [2:0]                  dbg_bus_state
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_LW = RX_AW + 1;
    localparam int TX_LW = TX_AW + 1;
    localparam logic [RX_LW-1:0] RX_FULL = RX_LW'(RX_DEPTH);
    localparam logic [TX_LW-1:0] TX_FULL = TX_LW'(TX_DEPTH);

    // S_WAIT: strobes not yet seen idle-high since reset or a bus fault; no edge is honoured.
    localparam logic [2:0] S_WAIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_WR    = 3'd2;
    localparam logic [2:0] S_RD    = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    logic [SYNC_STAGES-1:0] oe_sync_q;
    logic [SYNC_STAGES-1:0] we_sync_q;
    logic [SYNC_STAGES-1:0] vld_sync_q;
    logic [WIDTH-1:0]       d_sync_q [SYNC_STAGES];

    logic             oe_s;
    logic             we_s;
    logic             sync_ok;
    logic [WIDTH-1:0] d_s;
    logic             bus_fault;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] d_prev_q;
    logic             wr_done;
    logic             rd_start;
    logic             rd_end;

    logic [WIDTH-1:0] rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
    logic [RX_AW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
    logic [RX_LW-1:0] rx_level_q, rx_level_d;
    logic             rx_push;
    logic             rx_pop;
    logic             rx_full;
    logic             rx_ovf_set;

    logic [WIDTH-1:0] tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
    logic [TX_AW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
    logic [TX_LW-1:0] tx_level_q, tx_level_d;
    logic             tx_push;
    logic             tx_pop;
    logic             tx_full;
    logic             tx_empty;
    logic             tx_unr_set;

    logic             rd_had_data_q, rd_had_data_d;
    logic [WIDTH-1:0] smi_d_out_q, smi_d_out_d;
    logic             rx_ovf_q, rx_ovf_d;
    logic             tx_unr_q, tx_unr_d;

    // Strobes reset to idle-high; vld_sync_q marks when real pad samples reach the last stage.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            oe_sync_q  <= '1;
            we_sync_q  <= '1;
            vld_sync_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) d_sync_q[i] <= '0;
        end else begin
            oe_sync_q   <= {oe_sync_q[SYNC_STAGES-2:0], smi_oe_n};
            we_sync_q   <= {we_sync_q[SYNC_STAGES-2:0], smi_we_n};
            vld_sync_q  <= {vld_sync_q[SYNC_STAGES-2:0], 1'b1};
            d_sync_q[0] <= smi_d_in;
            for (int i = 1; i < SYNC_STAGES; i++) d_sync_q[i] <= d_sync_q[i-1];
        end
    end

    assign oe_s      = oe_sync_q[SYNC_STAGES-1];
    assign we_s      = we_sync_q[SYNC_STAGES-1];
    assign sync_ok   = vld_sync_q[SYNC_STAGES-1];
    assign d_s       = d_sync_q[SYNC_STAGES-1];
    assign bus_fault = sync_ok && !oe_s && !we_s;

    always_comb begin
        state_d  = state_q;
        wr_done  = 1'b0;
        rd_start = 1'b0;
        rd_end   = 1'b0;
        if (bus_fault) begin
            state_d = S_FAULT;
        end else begin
            case (state_q)
                S_WAIT:  if (sync_ok && oe_s && we_s) state_d = S_IDLE;
                S_IDLE: begin
                    if (!we_s) begin
                        state_d = S_WR;
                    end else if (!oe_s) begin
                        state_d  = S_RD;
                        rd_start = 1'b1;
                    end
                end
                S_WR: begin
                    if (we_s) begin
                        state_d = S_IDLE;
                        wr_done = 1'b1;
                    end
                end
                S_RD: begin
                    if (oe_s) begin
                        state_d = S_IDLE;
                        rd_end  = 1'b1;
                    end
                end
                S_FAULT: state_d = S_WAIT;
                default: state_d = S_WAIT;
            endcase
        end
    end

    // Stream handshakes: a word moves on a cycle where valid && ready are both high;
    // valid never waits on ready. tx_ready also rises when full if the Pi pops that
    // same cycle, so a full TX FIFO accepts a push alongside the pop.
    assign rx_full    = (rx_level_q == RX_FULL);
    assign rx_valid   = (rx_level_q != '0);
    assign rx_data    = rx_mem[rx_rd_ptr_q];
    assign rx_pop     = rx_valid && rx_ready;
    assign rx_push    = wr_done && (!rx_full || rx_pop);
    assign rx_ovf_set = wr_done && rx_full && !rx_pop;

    assign tx_full    = (tx_level_q == TX_FULL);
    assign tx_empty   = (tx_level_q == '0);
    assign tx_pop     = rd_end && rd_had_data_q;
    assign tx_ready   = !tx_full || tx_pop;
    assign tx_push    = tx_valid && tx_ready;
    assign tx_unr_set = rd_start && tx_empty;

    always_comb begin
        rx_wr_ptr_d   = rx_wr_ptr_q;
        rx_rd_ptr_d   = rx_rd_ptr_q;
        rx_level_d    = rx_level_q;
        tx_wr_ptr_d   = tx_wr_ptr_q;
        tx_rd_ptr_d   = tx_rd_ptr_q;
        tx_level_d    = tx_level_q;
        rd_had_data_d = rd_had_data_q;
        smi_d_out_d   = smi_d_out_q;

        if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + RX_AW'(1);
        if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + RX_AW'(1);
        case ({rx_push, rx_pop})
            2'b10:   rx_level_d = rx_level_q + RX_LW'(1);
            2'b01:   rx_level_d = rx_level_q - RX_LW'(1);
            default: rx_level_d = rx_level_q;
        endcase

        if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + TX_AW'(1);
        if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + TX_AW'(1);
        case ({tx_push, tx_pop})
            2'b10:   tx_level_d = tx_level_q + TX_LW'(1);
            2'b01:   tx_level_d = tx_level_q - TX_LW'(1);
            default: tx_level_d = tx_level_q;
        endcase

        // The emptiness seen at read start decides both the driven word and the later pop.
        if (rd_start) begin
            rd_had_data_d = !tx_empty;
            smi_d_out_d   = tx_empty ? IDLE_WORD : tx_mem[tx_rd_ptr_q];
        end

        rx_ovf_d = (rx_ovf_q && !flags_clr) || rx_ovf_set || bus_fault;
        tx_unr_d = (tx_unr_q && !flags_clr) || tx_unr_set || bus_fault;
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_WAIT;
            d_prev_q      <= '0;
            rx_wr_ptr_q   <= '0;
            rx_rd_ptr_q   <= '0;
            rx_level_q    <= '0;
            tx_wr_ptr_q   <= '0;
            tx_rd_ptr_q   <= '0;
            tx_level_q    <= '0;
            rd_had_data_q <= 1'b0;
            smi_d_out_q   <= IDLE_WORD;
            rx_ovf_q      <= 1'b0;
            tx_unr_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            d_prev_q      <= d_s;
            rx_wr_ptr_q   <= rx_wr_ptr_d;
            rx_rd_ptr_q   <= rx_rd_ptr_d;
            rx_level_q    <= rx_level_d;
            tx_wr_ptr_q   <= tx_wr_ptr_d;
            tx_rd_ptr_q   <= tx_rd_ptr_d;
            tx_level_q    <= tx_level_d;
            rd_had_data_q <= rd_had_data_d;
            smi_d_out_q   <= smi_d_out_d;
            rx_ovf_q      <= rx_ovf_d;
            tx_unr_q      <= tx_unr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (rx_push) rx_mem[rx_wr_ptr_q] <= d_prev_q;
        if (tx_push) tx_mem[tx_wr_ptr_q] <= tx_data;
    end

    assign smi_d_oe      = (state_q == S_RD) && !oe_s && we_s;
    assign smi_d_out     = smi_d_out_q;
    assign rx_level      = rx_level_q;
    assign tx_level      = tx_level_q;
    assign rx_overflow   = rx_ovf_q;
    assign tx_underrun   = tx_unr_q;
    assign dbg_bus_state = state_q;

endmodule

// File: tb/tb_smi_fifo_bridge.sv
// Directed bench for smi_fifo_bridge: an 8-bit instance with 4-deep FIFOs for the stream
// behaviour and a 16-bit instance for the both-strobes-low bus fault.
module tb_smi_fifo_bridge;

    localparam int OP_WR   = 0;
    localparam int OP_RD   = 1;
    localparam int OP_PUSH = 2;
    localparam int OP_POP  = 3;
    localparam int OP_CLR  = 4;
    localparam logic [7:0] IDLE8 = 8'hEE;

    typedef struct {
        int         op;
        logic [7:0] din;
        logic [7:0] exp_data;
        int         rx_lvl;
        int         tx_lvl;
        logic       ovf;
        logic       unr;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n;
    int         n_vec = 0;
    int         n_err = 0;

    logic       oe_n, we_n, rx_ready, tx_valid, clr;
    logic [7:0] din, dout, rx_data, tx_data;
    logic       doe, rx_valid, tx_ready, ovf, unr;
    logic [2:0] rx_level, tx_level, st8;

    logic        oe16_n, we16_n, rxr16, txv16, clr16;
    logic [15:0] din16, dout16, rxd16, txd16;
    logic        doe16, rxv16, txr16, ovf16, unr16;
    logic [4:0]  rxl16, txl16;
    logic [2:0]  st16;

    smi_fifo_bridge #(.WIDTH(8), .RX_DEPTH(4), .TX_DEPTH(4), .SYNC_STAGES(2), .IDLE_WORD(IDLE8)) u_dut8 (
        .CLK(clk), .reset_n(reset_n), .smi_oe_n(oe_n), .smi_we_n(we_n),
        .smi_d_in(din), .smi_d_out(dout), .smi_d_oe(doe),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_level(rx_level), .tx_level(tx_level),
        .rx_overflow(ovf), .tx_underrun(unr), .flags_clr(clr), .dbg_bus_state(st8)
    );

    smi_fifo_bridge #(.WIDTH(16)) u_dut16 (
        .CLK(clk), .reset_n(reset_n), .smi_oe_n(oe16_n), .smi_we_n(we16_n),
        .smi_d_in(din16), .smi_d_out(dout16), .smi_d_oe(doe16),
        .rx_data(rxd16), .rx_valid(rxv16), .rx_ready(rxr16),
        .tx_data(txd16), .tx_valid(txv16), .tx_ready(txr16),
        .rx_level(rxl16), .tx_level(txl16),
        .rx_overflow(ovf16), .tx_underrun(unr16), .flags_clr(clr16), .dbg_bus_state(st16)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic pi_write(input logic [7:0] d);
        din = d;
        step(2);
        we_n = 1'b0;
        step(6);
        we_n = 1'b1;
        step(6);
    endtask

    task automatic pi_read(output logic [7:0] q, output logic oe_mid);
        oe_n = 1'b0;
        step(6);
        q      = dout;
        oe_mid = doe;
        oe_n   = 1'b1;
        step(6);
    endtask

    vec_t       vq[$];
    logic [7:0] q;
    logic       oe_mid;

    initial begin
        reset_n = 1'b0;
        oe_n = 1'b1; we_n = 1'b1; din = '0; rx_ready = 1'b0;
        tx_valid = 1'b0; tx_data = '0; clr = 1'b0;
        oe16_n = 1'b1; we16_n = 1'b1; din16 = '0; rxr16 = 1'b0;
        txv16 = 1'b0; txd16 = '0; clr16 = 1'b0;

        // Reset values, checked while reset is still held.
        step(2);
        chk("reset smi_d_oe", 32'(doe), 32'd0);
        chk("reset smi_d_out", 32'(dout), 32'(IDLE8));
        chk("reset rx_valid", 32'(rx_valid), 32'd0);
        chk("reset tx_ready", 32'(tx_ready), 32'd1);
        chk("reset rx_level", 32'(rx_level), 32'd0);
        chk("reset tx_level", 32'(tx_level), 32'd0);
        chk("reset flags", 32'({ovf, unr}), 32'd0);
        reset_n = 1'b1;
        step(4);

        vq.push_back(vec_t'{OP_WR,  8'h45, 8'h00, 1, 0, 1'b0, 1'b0});
        vq.push_back(vec_t'{OP_WR,  8'h65, 8'h00, 2, 0, 1'b0, 1'b0});
        vq.push_back(vec_t'{OP_POP, 8'h00, 8'h45, 1, 0, 1'b0, 1'b0});
        vq.push_back(vec_t'{OP_POP, 8'h00, 8'h65, 0, 0, 1'b0, 1'b0});
        for (int k = 1; k <= 5; k++)
            vq.push_back(vec_t'{OP_WR, 8'(k), 8'h00, (k < 4) ? k : 4, 0, (k == 5), 1'b0});
        for (int k = 1; k <= 4; k++)
            vq.push_back(vec_t'{OP_POP, 8'h00, 8'(k), 4 - k, 0, 1'b1, 1'b0});
        vq.push_back(vec_t'{OP_CLR,  8'h00, 8'h00, 0, 0, 1'b0, 1'b0});
        vq.push_back(vec_t'{OP_PUSH, 8'hA5, 8'h00, 0, 1, 1'b0, 1'b0});
        vq.push_back(vec_t'{OP_PUSH, 8'h5A, 8'h00, 0, 2, 1'b0, 1'b0});
        vq.push_back(vec_t'{OP_RD,   8'h00, 8'hA5, 0, 1, 1'b0, 1'b0});
        vq.push_back(vec_t'{OP_RD,   8'h00, 8'h5A, 0, 0, 1'b0, 1'b0});
        vq.push_back(vec_t'{OP_RD,   8'h00, IDLE8, 0, 0, 1'b0, 1'b1});
        vq.push_back(vec_t'{OP_CLR,  8'h00, 8'h00, 0, 0, 1'b0, 1'b0});

        foreach (vq[i]) begin
            case (vq[i].op)
                OP_WR: pi_write(vq[i].din);
                OP_RD: begin
                    pi_read(q, oe_mid);
                    chk($sformatf("v%0d pi_data", i), 32'(q), 32'(vq[i].exp_data));
                    chk($sformatf("v%0d oe_during", i), 32'(oe_mid), 32'd1);
                    chk($sformatf("v%0d oe_after", i), 32'(doe), 32'd0);
                end
                OP_PUSH: begin
                    chk($sformatf("v%0d tx_ready", i), 32'(tx_ready), 32'd1);
                    tx_data  = vq[i].din;
                    tx_valid = 1'b1;
                    step(1);
                    tx_valid = 1'b0;
                end
                OP_POP: begin
                    chk($sformatf("v%0d rx_valid", i), 32'(rx_valid), 32'd1);
                    chk($sformatf("v%0d rx_data", i), 32'(rx_data), 32'(vq[i].exp_data));
                    rx_ready = 1'b1;
                    step(1);
                    rx_ready = 1'b0;
                end
                default: begin
                    clr = 1'b1;
                    step(1);
                    clr = 1'b0;
                end
            endcase
            chk($sformatf("v%0d rx_level", i), 32'(rx_level), 32'(vq[i].rx_lvl));
            chk($sformatf("v%0d tx_level", i), 32'(tx_level), 32'(vq[i].tx_lvl));
            chk($sformatf("v%0d rx_overflow", i), 32'(ovf), 32'(vq[i].ovf));
            chk($sformatf("v%0d tx_underrun", i), 32'(unr), 32'(vq[i].unr));
        end

        // Read from empty TX, fabric fills it mid-strobe: no pop, word kept for the next read.
        oe_n = 1'b0;
        step(6);
        chk("empty read smi_d_out", 32'(dout), 32'(IDLE8));
        chk("empty read smi_d_oe", 32'(doe), 32'd1);
        chk("empty read tx_underrun", 32'(unr), 32'd1);
        tx_data  = 8'h11;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        step(2);
        oe_n = 1'b1;
        step(6);
        chk("mid-strobe push kept", 32'(tx_level), 32'd1);
        pi_read(q, oe_mid);
        chk("late word read", 32'(q), 32'h11);
        chk("late word tx_level", 32'(tx_level), 32'd0);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("underrun cleared", 32'(unr), 32'd0);

        // Full TX: fabric holds a word while the Pi pops; both happen on the same edge.
        tx_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tx_data = 8'(k);
            step(1);
        end
        tx_valid = 1'b0;
        chk("tx full level", 32'(tx_level), 32'd4);
        chk("tx full ready", 32'(tx_ready), 32'd0);
        tx_data  = 8'h99;
        tx_valid = 1'b1;
        pi_read(q, oe_mid);
        tx_valid = 1'b0;
        chk("full read data", 32'(q), 32'h01);
        chk("full push+pop level", 32'(tx_level), 32'd4);
        for (int k = 2; k <= 5; k++) begin
            pi_read(q, oe_mid);
            chk($sformatf("drain %0d", k), 32'(q), (k == 5) ? 32'h99 : 32'(k));
        end
        chk("drain tx_level", 32'(tx_level), 32'd0);
        chk("drain tx_underrun", 32'(unr), 32'd0);

        // Reset in the middle of a Pi write: transfer abandoned, no push on release.
        din  = 8'h77;
        step(2);
        we_n = 1'b0;
        step(3);
        #2 reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(4);
        we_n = 1'b1;
        step(6);
        chk("abandoned write rx_level", 32'(rx_level), 32'd0);
        chk("abandoned write rx_valid", 32'(rx_valid), 32'd0);
        chk("abandoned write overflow", 32'(ovf), 32'd0);
        pi_write(8'h3C);
        chk("post-reset write level", 32'(rx_level), 32'd1);
        chk("post-reset write data", 32'(rx_data), 32'h3C);

        // 16-bit instance: preload one word each way, then hold both strobes low.
        txd16 = 16'h1234;
        txv16 = 1'b1;
        step(1);
        txv16 = 1'b0;
        din16 = 16'hBEEF;
        step(2);
        we16_n = 1'b0;
        step(6);
        we16_n = 1'b1;
        step(6);
        chk("w16 preload rx", 32'(rxl16), 32'd1);
        chk("w16 preload flags", 32'({ovf16, unr16}), 32'd0);
        oe16_n = 1'b0;
        we16_n = 1'b0;
        step(4);
        chk("fault smi_d_oe", 32'(doe16), 32'd0);
        step(4);
        oe16_n = 1'b1;
        we16_n = 1'b1;
        step(6);
        chk("fault rx_level", 32'(rxl16), 32'd1);
        chk("fault tx_level", 32'(txl16), 32'd1);
        chk("fault rx_data", 32'(rxd16), 32'hBEEF);
        chk("fault smi_d_out", 32'(dout16), 32'h0);
        chk("fault rx_overflow", 32'(ovf16), 32'd1);
        chk("fault tx_underrun", 32'(unr16), 32'd1);
        clr16 = 1'b1;
        step(1);
        clr16 = 1'b0;
        chk("fault flags cleared", 32'({ovf16, unr16}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
